// File: rtl/race_pkg.sv
// Shared widths, FSM encodings and arithmetic helpers for the race game-flow controller.
package race_pkg;

    localparam int unsigned SCROLL_W = 10;
    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned SPEED_W  = 3;
    localparam int unsigned LIVES_W  = 3;

    typedef logic [1:0] race_state_t;

    localparam race_state_t ST_IDLE  = 2'd0;
    localparam race_state_t ST_PLAY  = 2'd1;
    localparam race_state_t ST_CRASH = 2'd2;
    localparam race_state_t ST_OVER  = 2'd3;

    // Score never wraps; it pins at all-ones once the sum overflows.
    function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a,
                                                         input logic [SPEED_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W - SPEED_W + 1){1'b0}}, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Scan-position decode: registered once-per-frame tick at the start of vertical blanking,
// plus a combinational visible-pixel qualifier for the collision latch.
module frame_tick_gen #(
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_ACTIVE = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick_i,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output logic       frame_tick_o,
    output logic       visible_o
);

    logic frame_tick_q;
    logic frame_tick_d;

    assign frame_tick_d = p_tick_i && (pixel_y_i == 10'(V_ACTIVE)) && (pixel_x_i == 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick_o = frame_tick_q;
    assign visible_o    = p_tick_i && ({1'b0, pixel_x_i} < 11'(H_ACTIVE))
                                   && ({1'b0, pixel_y_i} < 11'(V_ACTIVE));

endmodule

// File: rtl/race_flow_ctrl.sv
// Game-flow scheduler: IDLE/PLAY/CRASH/OVER sequencing, scroll/speed/score and collision latch.
// Optional pause support is built when RACE_PAUSE_EN is defined.
module race_flow_ctrl
    import race_pkg::*;
#(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned CRASH_FRAMES = 60,
    parameter int unsigned SPEED_MAX    = 4,
    parameter int unsigned ACCEL_FRAMES = 32,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned H_ACTIVE     = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick_i,
    input  logic [9:0]  pixel_x_i,
    input  logic [9:0]  pixel_y_i,
    input  logic        start_i,
    input  logic        on_player_i,
    input  logic        on_enemy_i,
`ifdef RACE_PAUSE_EN
    input  logic        pause_i,
    output logic        paused_o,
`endif
    output logic [1:0]  state_o,
    output logic        run_o,
    output logic        frame_tick_o,
    output logic [9:0]  scroll_o,
    output logic [2:0]  speed_o,
    output logic [2:0]  lives_o,
    output logic [15:0] score_o,
    output logic        blink_o
);

    localparam int unsigned CntW = (CRASH_FRAMES > 16) ? $clog2(CRASH_FRAMES) : 4;
    localparam int unsigned AccW = (ACCEL_FRAMES > 2) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);
    localparam logic [SPEED_W-1:0] SpeedMax  = SPEED_W'(SPEED_MAX);
    localparam logic [CntW-1:0]    CrashLast = CntW'(CRASH_FRAMES - 1);
    localparam logic [AccW-1:0]    AccLast   = AccW'(ACCEL_FRAMES - 1);

    logic frame_tick;
    logic visible;

    frame_tick_gen #(
        .V_ACTIVE (V_ACTIVE),
        .H_ACTIVE (H_ACTIVE)
    ) u_frame_tick_gen (
        .clk          (clk),
        .reset        (reset),
        .p_tick_i     (p_tick_i),
        .pixel_x_i    (pixel_x_i),
        .pixel_y_i    (pixel_y_i),
        .frame_tick_o (frame_tick),
        .visible_o    (visible)
    );

    race_state_t         state_q, state_d;
    logic                run_q, run_d;
    logic [SCROLL_W-1:0] scroll_q, scroll_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                blink_q, blink_d;
    logic [CntW-1:0]     crash_cnt_q, crash_cnt_d;
    logic [AccW-1:0]     accel_q, accel_d;
    logic                start_q;
    logic                start_pend_q, start_pend_d;
    logic                hit_q, hit_d;
    logic                start_rise;
    logic                motion_en;
    logic                hit_set;

`ifdef RACE_PAUSE_EN
    logic pause_q;
    logic paused_q, paused_d;
    logic pause_pend_q, pause_pend_d;
    logic pause_rise;

    assign pause_rise = pause_i && !pause_q;
    assign motion_en  = !paused_q;
`else
    assign motion_en  = 1'b1;
`endif

    assign start_rise = start_i && !start_q;
    assign hit_set    = visible && on_player_i && on_enemy_i && (state_q == ST_PLAY) && motion_en;

    always_comb begin
        state_d      = state_q;
        scroll_d     = scroll_q;
        speed_d      = speed_q;
        lives_d      = lives_q;
        score_d      = score_q;
        blink_d      = blink_q;
        crash_cnt_d  = crash_cnt_q;
        accel_d      = accel_q;
        start_pend_d = start_pend_q;
        hit_d        = hit_q || hit_set;
`ifdef RACE_PAUSE_EN
        paused_d     = paused_q;
        pause_pend_d = pause_pend_q;
`endif

        if (frame_tick) begin
            hit_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    lives_d = LivesInit;
                    score_d = '0;
                    if (start_pend_q) begin
                        state_d      = ST_PLAY;
                        speed_d      = SPEED_W'(1);
                        accel_d      = '0;
                        start_pend_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (motion_en) begin
                        if (hit_q) begin
                            speed_d     = '0;
                            crash_cnt_d = '0;
                            if (lives_q > LIVES_W'(1)) begin
                                state_d = ST_CRASH;
                                lives_d = lives_q - 1'b1;
                            end else begin
                                state_d = ST_OVER;
                                lives_d = '0;
                            end
                        end else begin
                            scroll_d = scroll_q + {{(SCROLL_W - SPEED_W){1'b0}}, speed_q};
                            score_d  = sat_add_score(score_q, speed_q);
                            if (accel_q == AccLast) begin
                                accel_d = '0;
                                if (speed_q < SpeedMax) begin
                                    speed_d = speed_q + 1'b1;
                                end
                            end else begin
                                accel_d = accel_q + 1'b1;
                            end
                        end
                    end
                end
                ST_CRASH: begin
                    if (crash_cnt_q == CrashLast) begin
                        state_d = ST_PLAY;
                        speed_d = SPEED_W'(1);
                        accel_d = '0;
                        blink_d = 1'b0;
                    end else begin
                        crash_cnt_d = crash_cnt_q + 1'b1;
                        blink_d     = crash_cnt_d[3];
                    end
                end
                default: begin
                    blink_d = 1'b0;
                    if (start_pend_q) begin
                        state_d      = ST_IDLE;
                        lives_d      = LivesInit;
                        score_d      = '0;
                        start_pend_d = 1'b0;
                    end
                end
            endcase
`ifdef RACE_PAUSE_EN
            // A pending pause edge only matters while staying in PLAY; leaving PLAY unpauses.
            paused_d     = (state_q == ST_PLAY && state_d == ST_PLAY) ? (paused_q ^ pause_pend_q)
                                                                       : 1'b0;
            pause_pend_d = 1'b0;
`endif
        end

        // New edges win over a same-cycle consume so a press is never lost.
        if (start_rise && (state_q != ST_CRASH)) begin
            start_pend_d = 1'b1;
        end
`ifdef RACE_PAUSE_EN
        if (pause_rise && (state_q == ST_PLAY)) begin
            pause_pend_d = 1'b1;
        end
        run_d = (state_d == ST_PLAY) && !paused_d;
`else
        run_d = (state_d == ST_PLAY);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            scroll_q     <= '0;
            speed_q      <= '0;
            lives_q      <= LivesInit;
            score_q      <= '0;
            blink_q      <= 1'b0;
            crash_cnt_q  <= '0;
            accel_q      <= '0;
            start_q      <= 1'b0;
            start_pend_q <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            scroll_q     <= scroll_d;
            speed_q      <= speed_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            blink_q      <= blink_d;
            crash_cnt_q  <= crash_cnt_d;
            accel_q      <= accel_d;
            start_q      <= start_i;
            start_pend_q <= start_pend_d;
            hit_q        <= hit_d;
        end
    end

`ifdef RACE_PAUSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_q      <= 1'b0;
            paused_q     <= 1'b0;
            pause_pend_q <= 1'b0;
        end else begin
            pause_q      <= pause_i;
            paused_q     <= paused_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    assign paused_o = paused_q;
`endif

    assign state_o      = state_q;
    assign run_o        = run_q;
    assign frame_tick_o = frame_tick;
    assign scroll_o     = scroll_q;
    assign speed_o      = speed_q;
    assign lives_o      = lives_q;
    assign score_o      = score_q;
    assign blink_o      = blink_q;

endmodule

// File: tb/tb_race_flow_ctrl.sv
// Randomized frame-level bench for race_flow_ctrl against a game-rule reference model.
module tb_race_flow_ctrl;

    localparam int LIVES_INIT   = 3;
    localparam int CRASH_FRAMES = 60;
    localparam int SPEED_MAX    = 4;
    localparam int ACCEL_FRAMES = 32;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_CRASH = 2, ST_OVER = 3;

    logic        clk;
    logic        reset;
    logic        p_tick_i, start_i, on_player_i, on_enemy_i;
    logic [9:0]  pixel_x_i, pixel_y_i;
    logic [1:0]  state_o;
    logic        run_o, frame_tick_o, blink_o;
    logic [9:0]  scroll_o;
    logic [2:0]  speed_o, lives_o;
    logic [15:0] score_o;
`ifdef RACE_PAUSE_EN
    logic        pause_i, paused_o;
`endif

    int vectors, miscompares;
    int ft_acc;

    // Reference model, frame granularity
    int m_state, m_lives, m_score, m_scroll, m_speed, m_play_frames, m_crash_k;
    bit m_blink, m_pend, m_hit, m_paused, m_ppend;
    bit pause_req;

    race_flow_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .p_tick_i     (p_tick_i),
        .pixel_x_i    (pixel_x_i),
        .pixel_y_i    (pixel_y_i),
        .start_i      (start_i),
        .on_player_i  (on_player_i),
        .on_enemy_i   (on_enemy_i),
`ifdef RACE_PAUSE_EN
        .pause_i      (pause_i),
        .paused_o     (paused_o),
`endif
        .state_o      (state_o),
        .run_o        (run_o),
        .frame_tick_o (frame_tick_o),
        .scroll_o     (scroll_o),
        .speed_o      (speed_o),
        .lives_o      (lives_o),
        .score_o      (score_o),
        .blink_o      (blink_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_speed(input int pf);
        int s;
        s = 1 + pf / ACCEL_FRAMES;
        return (s > SPEED_MAX) ? SPEED_MAX : s;
    endfunction

    function automatic logic [36:0] exp_vec();
        return {1'b1, 2'(m_state), (m_state == ST_PLAY && !m_paused), 10'(m_scroll),
                3'(m_speed), 3'(m_lives), 16'(m_score), m_blink};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_lives = LIVES_INIT; m_score = 0; m_scroll = 0; m_speed = 0;
        m_play_frames = 0; m_crash_k = 0; m_blink = 0; m_pend = 0; m_hit = 0;
        m_paused = 0; m_ppend = 0;
    endtask

    task automatic model_frame();
        int old_state;
        old_state = m_state;
        case (m_state)
            ST_IDLE: begin
                m_lives = LIVES_INIT; m_score = 0;
                if (m_pend) begin
                    m_pend = 0; m_state = ST_PLAY; m_speed = 1; m_play_frames = 0;
                end
            end
            ST_PLAY: if (!m_paused) begin
                if (m_hit) begin
                    m_state = (m_lives > 1) ? ST_CRASH : ST_OVER;
                    m_lives = m_lives - 1; m_speed = 0; m_crash_k = 0;
                end else begin
                    m_scroll = (m_scroll + m_speed) % 1024;
                    m_score  = (m_score + m_speed > 65535) ? 65535 : m_score + m_speed;
                    m_play_frames++;
                    m_speed = exp_speed(m_play_frames);
                end
            end
            ST_CRASH: begin
                m_crash_k++;
                if (m_crash_k == CRASH_FRAMES) begin
                    m_state = ST_PLAY; m_speed = 1; m_play_frames = 0; m_blink = 0;
                end else begin
                    m_blink = ((m_crash_k / 8) % 2) == 1;
                end
            end
            default: if (m_pend) begin
                m_pend = 0; m_state = ST_IDLE; m_lives = LIVES_INIT; m_score = 0;
            end
        endcase
        if (old_state == ST_PLAY) m_paused = (m_state == ST_PLAY) ? (m_paused ^ m_ppend) : 1'b0;
        m_ppend = 0;
        m_hit   = 0;
    endtask

    task automatic cyc(input bit pt, input int x, input int y, input bit op, input bit oe,
                       input bit st, input bit pz);
        p_tick_i = pt; pixel_x_i = 10'(x); pixel_y_i = 10'(y);
        on_player_i = op; on_enemy_i = oe; start_i = st;
`ifdef RACE_PAUSE_EN
        pause_i = pz;
`endif
        @(posedge clk);
        #1;
        ft_acc += int'(frame_tick_o);
    endtask

    // One frame: visible pixels, optional off-screen/no-tick overlap decoys, then the tick.
    task automatic do_frame(input int npix, input bit hit_req, input bit start_req,
                            input bit decoys, output logic [36:0] obs);
        ft_acc = 0;
        for (int i = 0; i < npix; i++) begin
            bit op, oe;
            int x, y;
            if (hit_req && i == 0) begin
                x = 100; y = 200; op = 1; oe = 1;
            end else begin
                x = int'($urandom_range(639)); y = int'($urandom_range(479));
                op = 1'($urandom_range(1));
                oe = op ? 1'b0 : 1'($urandom_range(1));
            end
            cyc(1, x, y, op, oe, start_req && i == 0, pause_req && i == 0);
        end
        if (decoys) begin
            cyc(1, 640 + int'($urandom_range(159)), int'($urandom_range(524)), 1, 1, 0, 0);
            cyc(1, int'($urandom_range(639)), 481 + int'($urandom_range(43)), 1, 1, 0, 0);
            cyc(0, int'($urandom_range(639)), int'($urandom_range(479)), 1, 1, 0, 0);
        end
        if (npix > 0) begin
            if (hit_req && m_state == ST_PLAY && !m_paused) m_hit = 1;
            if (start_req && m_state != ST_CRASH) m_pend = 1;
            if (pause_req && m_state == ST_PLAY) m_ppend = 1;
        end
        cyc(1, 0, 480, 0, 0, 0, 0);
        cyc(0, 1, 480, 0, 0, 0, 0);
        model_frame();
        obs = {ft_acc == 1, state_o, run_o, scroll_o, speed_o, lives_o, score_o, blink_o};
    endtask

    task automatic reset_dut();
        p_tick_i = 0; pixel_x_i = 0; pixel_y_i = 0; start_i = 0;
        on_player_i = 0; on_enemy_i = 0; pause_req = 0;
`ifdef RACE_PAUSE_EN
        pause_i = 0;
`endif
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [36:0] obs;
        reset_dut();
        reset = 1;
        #2;
        vectors++;
        if ({state_o, run_o, frame_tick_o, scroll_o, speed_o, lives_o, score_o, blink_o} !==
            {2'd0, 1'b0, 1'b0, 10'd0, 3'd0, 3'd3, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got st=%0d run=%0d ft=%0d scr=%0d spd=%0d liv=%0d sc=%0d bl=%0d",
                     state_o, run_o, frame_tick_o, scroll_o, speed_o, lives_o, score_o, blink_o);
        end
        reset_dut();
        for (int f = 0; f < 2; f++) begin
            do_frame(3, 0, 0, 1, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL idle_frame: got %h expected %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_start_accel();
        logic [36:0] obs;
        reset_dut();
        do_frame(3, 0, 1, 1, obs);
        vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL start_play: got %h expected %h", obs, exp_vec()); end
        for (int f = 0; f < 130; f++) begin
            do_frame(int'($urandom_range(1, 3)), 0, 0, 1, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL accel: got %h expected %h", obs, exp_vec()); end
        end
        vectors++;
        if (speed_o !== 3'd4) begin miscompares++; $display("FAIL speed_sat: got %0d expected 4", speed_o); end
    endtask

    task automatic test_wrap();
        logic [36:0] obs;
        bit wrapped;
        int prev;
        wrapped = 0;
        prev = int'(scroll_o);
        for (int f = 0; f < 300; f++) begin
            do_frame(1, 0, 0, 0, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL wrap: got %h expected %h", obs, exp_vec()); end
            if (int'(scroll_o) < prev) wrapped = 1;
            prev = int'(scroll_o);
        end
        vectors++;
        if (wrapped !== 1'b1) begin miscompares++; $display("FAIL wrap_seen: got %0d expected 1", wrapped); end
    endtask

    task automatic test_collision();
        logic [36:0] obs;
        reset_dut();
        do_frame(2, 0, 1, 1, obs);
        vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL col_start: got %h expected %h", obs, exp_vec()); end
        do_frame(2, 1, 0, 1, obs);
        vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL col_hit: got %h expected %h", obs, exp_vec()); end
        vectors++;
        if (state_o !== 2'd2 || lives_o !== 3'd2) begin
            miscompares++; $display("FAIL col_crash_entry: got st=%0d liv=%0d expected st=2 liv=2", state_o, lives_o);
        end
        for (int k = 1; k <= CRASH_FRAMES; k++) begin
            do_frame(2, 0, k == 10, 1, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL col_crash: got %h expected %h", obs, exp_vec()); end
        end
        vectors++;
        if (state_o !== 2'd1 || speed_o !== 3'd1) begin
            miscompares++; $display("FAIL col_resume: got st=%0d spd=%0d expected st=1 spd=1", state_o, speed_o);
        end
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) begin
                do_frame(2, 0, 0, 1, obs);
                vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL col_play: got %h expected %h", obs, exp_vec()); end
            end
            do_frame(2, 1, 0, 1, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL col_hit2: got %h expected %h", obs, exp_vec()); end
            if (c == 0) begin
                for (int k = 0; k < CRASH_FRAMES; k++) begin
                    do_frame(1, 0, 0, 1, obs);
                    vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL col_crash2: got %h expected %h", obs, exp_vec()); end
                end
            end
        end
        vectors++;
        if (state_o !== 2'd3 || lives_o !== 3'd0) begin
            miscompares++; $display("FAIL col_over: got st=%0d liv=%0d expected st=3 liv=0", state_o, lives_o);
        end
        for (int k = 0; k < 3; k++) begin
            do_frame(2, 0, 0, 1, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL over_hold: got %h expected %h", obs, exp_vec()); end
        end
        do_frame(2, 0, 1, 1, obs);
        vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL over_to_idle: got %h expected %h", obs, exp_vec()); end
        vectors++;
        if (state_o !== 2'd0 || lives_o !== 3'd3 || score_o !== 16'd0) begin
            miscompares++; $display("FAIL idle_reload: got st=%0d liv=%0d sc=%0d expected 0 3 0", state_o, lives_o, score_o);
        end
        do_frame(2, 0, 1, 1, obs);
        vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL idle_to_play: got %h expected %h", obs, exp_vec()); end
    endtask

    task automatic test_reset_mid_crash();
        logic [36:0] obs;
        reset_dut();
        do_frame(2, 0, 1, 1, obs);
        for (int k = 0; k < 5; k++) do_frame(1, 0, 0, 0, obs);
        do_frame(2, 1, 0, 1, obs);
        for (int k = 0; k < 30; k++) do_frame(1, 0, 0, 0, obs);
        vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL crash30: got %h expected %h", obs, exp_vec()); end
        p_tick_i = 1; pixel_x_i = 10'd0; pixel_y_i = 10'd480;
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        vectors++;
        if ({state_o, run_o, frame_tick_o, scroll_o, speed_o, lives_o, score_o, blink_o} !==
            {2'd0, 1'b0, 1'b0, 10'd0, 3'd0, 3'd3, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got st=%0d run=%0d ft=%0d scr=%0d spd=%0d liv=%0d sc=%0d bl=%0d",
                     state_o, run_o, frame_tick_o, scroll_o, speed_o, lives_o, score_o, blink_o);
        end
        p_tick_i = 0;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            do_frame(2, 0, 0, 1, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL post_reset: got %h expected %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        logic [36:0] obs;
        reset_dut();
        for (int f = 0; f < 500; f++) begin
            int  n;
            bit  h, s;
            n = int'($urandom_range(4));
            h = (n > 0) && ($urandom_range(29) == 0);
            s = (n > 0) && ($urandom_range(14) == 0);
            do_frame(n, h, s, 1'($urandom_range(1)), obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL random: got %h expected %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_score_saturation();
        logic [36:0] obs;
        int extra;
        reset_dut();
        do_frame(2, 0, 1, 0, obs);
        extra = 0;
        for (int f = 0; f < 20000 && extra < 5; f++) begin
            do_frame(0, 0, 0, 0, obs);
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL score_run: got %h expected %h", obs, exp_vec()); end
            if (m_score == 65535) extra++;
        end
        vectors++;
        if (score_o !== 16'hFFFF) begin miscompares++; $display("FAIL score_sat: got %h expected ffff", score_o); end
    endtask

`ifdef RACE_PAUSE_EN
    task automatic test_pause();
        logic [36:0] obs;
        reset_dut();
        do_frame(2, 0, 1, 1, obs);
        for (int k = 0; k < 14; k++) begin
            pause_req = (k == 3) || (k == 10);
            do_frame(2, (k > 4 && k < 9), 0, 1, obs);
            pause_req = 0;
            vectors++; if (obs !== exp_vec()) begin miscompares++; $display("FAIL pause: got %h expected %h", obs, exp_vec()); end
            vectors++; if (paused_o !== m_paused) begin miscompares++; $display("FAIL paused_flag: got %0d expected %0d", paused_o, m_paused); end
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1;
        test_reset();
        test_start_accel();
        test_wrap();
        test_collision();
        test_reset_mid_crash();
        test_random();
        test_score_saturation();
`ifdef RACE_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/race_flow_ctrl.md
Name: race_flow_ctrl

Overview:
Game-flow scheduler for the road-racing display pipeline. Derives a once-per-frame tick from the VGA scan position and sequences the game through idle, playing, crash and game-over phases. Gates player/enemy motion and advances the road scroll offset, speed and score. Detects player/enemy collisions from the per-pixel "on" flags feeding the graphic priority mux.

Parameters:
LIVES_INIT, 3, lives loaded on entry to PLAY from IDLE (1..7)
CRASH_FRAMES, 60, frames spent in CRASH before resuming
SPEED_MAX, 4, maximum scroll speed in pixels/frame (1..7)
ACCEL_FRAMES, 32, frames between speed increments
V_ACTIVE, 480, first non-visible scan line
H_ACTIVE, 640, first non-visible pixel column

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
p_tick  in  1  pixel-rate enable from vga_sync
pixel_x  in  10  current scan column
pixel_y  in  10  current scan line
start  in  1  start button, synchronous level
on_player  in  1  player car covers current pixel
on_enemy  in  1  any enemy car covers current pixel
state  out  2  0=IDLE 1=PLAY 2=CRASH 3=OVER
run  out  1  motion enable for player/enemy blocks
frame_tick  out  1  one-cycle pulse per frame
scroll  out  10  road scroll offset
speed  out  3  current speed
lives  out  3  remaining lives
score  out  16  accumulated distance
blink  out  1  crash flash for player sprite

Behaviour:
- Reset values: state=IDLE, run=0, frame_tick=0, scroll=0, speed=0, lives=LIVES_INIT, score=0, blink=0; all internal counters/flags 0.
- frame_tick: registered; asserts the cycle after p_tick && pixel_y==V_ACTIVE && pixel_x==0. Exactly one per frame. All state/counter updates below occur only on frame_tick cycles unless stated otherwise.
- start_pend: set on start rising edge (edge detector registered on clk). Cleared on the frame_tick that consumes it. Edges in CRASH are ignored and not latched.
- hit flag: set on any p_tick with on_player && on_enemy && pixel_x<H_ACTIVE && pixel_y<V_ACTIVE while state==PLAY. Cleared on every frame_tick. A set and a clear in the same cycle resolve to clear.
- IDLE: run=0, scroll frozen, lives=LIVES_INIT, score=0. On frame_tick with start_pend -> PLAY, speed=1, accel counter=0.
- PLAY: run=1. On frame_tick:
  - If hit: lives-=1, speed=0, frame counter=0. Go to CRASH if old lives>1, else go to OVER with lives=0. Scroll and score are not updated this frame.
  - Else: scroll=(scroll+speed) mod 1024, wrapping with no flag. score=min(score+speed, 16'hFFFF). Accel counter increments. When it equals ACCEL_FRAMES-1, it resets to 0 and speed increments if speed<SPEED_MAX; otherwise speed holds.
- CRASH: run=0, scroll/score frozen, frame counter increments per frame_tick, blink=frame counter[3]. When counter reaches CRASH_FRAMES-1 -> PLAY with speed=1, accel counter=0, blink=0.
- OVER: run=0, blink=0, score held for display. On frame_tick with start_pend -> IDLE, which reloads lives and clears score.
- Outputs are registered. state/run change the cycle after frame_tick.
- Reset asserted mid-frame or mid-crash: immediate asynchronous return to reset values. No partial frame update survives.

Optional Feature:
RACE_PAUSE_EN
- With the macro: adds input port pause (1 bit) and output port paused (1 bit, reset 0).
  - A pause rising edge in PLAY toggles paused on the next frame_tick.
  - While paused: run=0; scroll, score, speed and accel counter are frozen; hit detection is disabled.
  - Leaving PLAY for any reason clears paused.
- Without the macro: neither port exists and behaviour is as above.

Decomposition:
- Package race_pkg holds: state encodings (ST_IDLE, ST_PLAY, ST_CRASH, ST_OVER), SCROLL_W=10, SCORE_W=16, SPEED_W=3, LIVES_W=3.
- One sub-module, frame_tick_gen: scan-position compare plus output register; parameters V_ACTIVE and H_ACTIVE.
- The FSM, counters and collision latch stay in race_flow_ctrl.

Test Plan:
- Reset, then run 2 frames with start low -> state=0, run=0, scroll=0, lives=3, exactly one frame_tick per frame.
- Pulse start mid-frame -> PLAY at next frame_tick, speed=1. After 32 frames speed=2. Speed saturates at 4 by frame 128. Score equals the sum of speeds.
- Hold speed=4 over 300 frames -> scroll wraps 1020->0 (mod 1024), no glitch. Force score near 16'hFFFE -> saturates at 16'hFFFF.
- Overlap on_player/on_enemy for one pixel at (100,200) -> at next frame_tick lives 3->2, state=2, blink toggles every 8 frames. After 60 frames state=1, speed=1.
- Three collisions -> lives=0, state=3. A start pulse leads to IDLE, lives=3, score=0. A start pulse during CRASH is ignored.
- Assert reset during CRASH frame 30 -> all outputs at reset values the same cycle. With RACE_PAUSE_EN: pause in PLAY freezes scroll/score and masks collisions until the next pause edge.
